uart_tx_frame: RTL and testbench



---
 rtl/uart_tx_frame.sv | 136 +++++++++++++
 tb/tb_uart_tx_frame.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: 8N1 / 8E1 / 8O1 UART transmitter.
// One byte is accepted from IDLE on DATA_VALID and sent as start bit,
// 8 data bits LSB first, optional parity bit and one stop bit, each bit
// held for N = max(Prescale, 4) clock cycles.
//
// Handshake: a byte is taken in any cycle where busy=0 (state IDLE) and
// DATA_VALID=1; while busy=1 DATA_VALID is ignored and nothing is queued,
// so the source must hold DATA_VALID until it sees busy rise.
module uart_tx_frame (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] P_DATA,
  input  logic       DATA_VALID,
  input  logic       PAR_EN,
  input  logic       PAR_TYP,
  input  logic [5:0] Prescale,
  output logic       TX_OUT,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t     state;
  logic [7:0] data_q;
  logic       par_en_q;
  logic       par_typ_q;
  logic [5:0] n_q;
  logic [5:0] cnt;
  logic [2:0] idx;

  logic       bit_done;
  logic [2:0] idx_next;
  logic [5:0] n_clamped;

  // Bit boundary detection and the clamped bit period for a new frame.
  always_comb begin
    bit_done  = (cnt == (n_q - 6'd1));
    idx_next  = idx + 3'd1;
    n_clamped = (Prescale < 6'd4) ? 6'd4 : Prescale;
  end

  // Frame sequencer: state, bit counters and registered line/busy outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      TX_OUT    <= 1'b1;
      busy      <= 1'b0;
      cnt       <= 6'd0;
      idx       <= 3'd0;
      data_q    <= 8'd0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      n_q       <= 6'd4;
    end else begin
      case (state)
        IDLE: begin
          TX_OUT <= 1'b1;
          busy   <= 1'b0;
          cnt    <= 6'd0;
          idx    <= 3'd0;
          if (DATA_VALID) begin
            data_q    <= P_DATA;
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
            n_q       <= n_clamped;
            state     <= START;
            TX_OUT    <= 1'b0;
            busy      <= 1'b1;
          end
        end
        START: begin
          if (bit_done) begin
            cnt    <= 6'd0;
            state  <= DATA;
            TX_OUT <= data_q[0];
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        DATA: begin
          if (bit_done) begin
            cnt <= 6'd0;
            if (idx == 3'd7) begin
              idx <= 3'd0;
              if (par_en_q) begin
                state  <= PARITY;
                TX_OUT <= (^data_q) ^ par_typ_q;
              end else begin
                state  <= STOP;
                TX_OUT <= 1'b1;
              end
            end else begin
              idx    <= idx_next;
              TX_OUT <= data_q[idx_next];
            end
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        PARITY: begin
          if (bit_done) begin
            cnt    <= 6'd0;
            state  <= STOP;
            TX_OUT <= 1'b1;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        STOP: begin
          if (bit_done) begin
            cnt    <= 6'd0;
            state  <= IDLE;
            busy   <= 1'b0;
            TX_OUT <= 1'b1;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          TX_OUT <= 1'b1;
          cnt    <= 6'd0;
          idx    <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: self-checking bench for uart_tx_frame.
// Expected {busy, TX_OUT} per clock cycle is queued when a frame is
// requested and compared cycle by cycle on the falling clock edge.
module tb_uart_tx_frame;

  logic       clk;
  logic       rst;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] Prescale;
  logic       TX_OUT;
  logic       busy;

  int checks;
  int failures;
  logic [1:0] exp_q[$];

  uart_tx_frame dut (
    .clk        (clk),
    .rst        (rst),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .Prescale   (Prescale),
    .TX_OUT     (TX_OUT),
    .busy       (busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard model ----------------
  // Push one expected {busy, TX_OUT} entry per clock cycle of a frame.
  task automatic push_frame(input logic [7:0] d, input logic pe, input logic pt,
                            input logic [5:0] ps);
    int   n;
    int   ones;
    logic seq[$];
    n    = (ps < 6'd4) ? 4 : int'(ps);
    ones = 0;
    seq.push_back(1'b0);
    for (int k = 0; k < 8; k++) begin
      seq.push_back(d[k]);
      if (d[k]) ones++;
    end
    if (pe) begin
      // even: total ones incl. parity even; odd: total ones odd
      if (pt) seq.push_back((ones % 2) == 0);
      else    seq.push_back((ones % 2) == 1);
    end
    seq.push_back(1'b1);
    foreach (seq[j]) begin
      for (int r = 0; r < n; r++) exp_q.push_back({1'b1, seq[j]});
    end
  endtask

  // ---------------- driver ----------------
  // One-cycle DATA_VALID pulse; returns in the first cycle after accept.
  task automatic start_frame(input logic [7:0] d, input logic pe, input logic pt,
                             input logic [5:0] ps);
    @(negedge clk);
    P_DATA     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    Prescale   = ps;
    DATA_VALID = 1'b1;
    push_frame(d, pe, pt, ps);
    @(negedge clk);
    DATA_VALID = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst        = 1'b1;
    DATA_VALID = 1'b1;
    P_DATA     = 8'h00;
    repeat (2) @(negedge clk);
    checks++;
    if (TX_OUT !== 1'b1) begin
      failures++;
      $display("FAIL reset_tx got=%b exp=1", TX_OUT);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy got=%b exp=0", busy);
    end
    rst        = 1'b0;
    DATA_VALID = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, TX_OUT} !== 2'b01) begin
      failures++;
      $display("FAIL reset_idle got=%b exp=01", {busy, TX_OUT});
    end
  endtask

  task automatic test_plain();
    int i;
    int busy_cycles;
    logic [1:0] e;
    start_frame(8'hA5, 1'b0, 1'b0, 6'd8);
    i = 0;
    busy_cycles = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({busy, TX_OUT} !== e) begin
        failures++;
        $display("FAIL plain cyc=%0d got=%b exp=%b", i, {busy, TX_OUT}, e);
      end
      if (busy) busy_cycles++;
      @(negedge clk);
      i++;
    end
    checks++;
    if ({busy, TX_OUT} !== 2'b01) begin
      failures++;
      $display("FAIL plain_end got=%b exp=01", {busy, TX_OUT});
    end
    checks++;
    if (busy_cycles != 80) begin
      failures++;
      $display("FAIL plain_busy_len got=%0d exp=80", busy_cycles);
    end
  endtask

  task automatic test_even_parity();
    int i;
    int busy_cycles;
    logic [1:0] e;
    start_frame(8'h07, 1'b1, 1'b0, 6'd16);
    i = 0;
    busy_cycles = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({busy, TX_OUT} !== e) begin
        failures++;
        $display("FAIL even cyc=%0d got=%b exp=%b", i, {busy, TX_OUT}, e);
      end
      if (i == 9 * 16 + 8) begin
        checks++;
        if (TX_OUT !== 1'b1) begin
          failures++;
          $display("FAIL even_parity_bit got=%b exp=1", TX_OUT);
        end
      end
      if (busy) busy_cycles++;
      @(negedge clk);
      i++;
    end
    checks++;
    if (busy_cycles != 176 || {busy, TX_OUT} !== 2'b01) begin
      failures++;
      $display("FAIL even_len got=%0d/%b exp=176/01", busy_cycles, {busy, TX_OUT});
    end
  endtask

  task automatic test_odd_parity();
    int i;
    logic [1:0] e;
    start_frame(8'h01, 1'b1, 1'b1, 6'd8);
    i = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({busy, TX_OUT} !== e) begin
        failures++;
        $display("FAIL odd cyc=%0d got=%b exp=%b", i, {busy, TX_OUT}, e);
      end
      if (i == 9 * 8 + 4) begin
        checks++;
        if (TX_OUT !== 1'b0) begin
          failures++;
          $display("FAIL odd_parity_bit got=%b exp=0", TX_OUT);
        end
      end
      // Inputs wander mid-frame; the latched frame must not notice.
      if (i == 20) begin
        P_DATA   = 8'hFE;
        PAR_TYP  = 1'b0;
        PAR_EN   = 1'b0;
        Prescale = 6'd5;
      end
      if (i == 70) begin
        P_DATA  = 8'h3C;
        PAR_TYP = 1'b0;
      end
      @(negedge clk);
      i++;
    end
    checks++;
    if ({busy, TX_OUT} !== 2'b01) begin
      failures++;
      $display("FAIL odd_end got=%b exp=01", {busy, TX_OUT});
    end
  endtask

  task automatic test_back_to_back();
    int i;
    int second_start;
    logic prev_busy;
    logic [1:0] e;
    @(negedge clk);
    P_DATA     = 8'h55;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    Prescale   = 6'd8;
    DATA_VALID = 1'b1;
    push_frame(8'h55, 1'b0, 1'b0, 6'd8);
    exp_q.push_back(2'b01);
    push_frame(8'hAA, 1'b0, 1'b0, 6'd8);
    for (int k = 0; k < 24; k++) exp_q.push_back(2'b01);
    @(negedge clk);
    i = 0;
    second_start = -1;
    prev_busy = 1'b1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({busy, TX_OUT} !== e) begin
        failures++;
        $display("FAIL b2b cyc=%0d got=%b exp=%b", i, {busy, TX_OUT}, e);
      end
      if (busy && !prev_busy && second_start < 0) second_start = i;
      prev_busy = busy;
      if (i == 0) P_DATA = 8'hAA;
      if (i == 91) DATA_VALID = 1'b0;
      if (i == 121) begin
        P_DATA     = 8'h33;
        DATA_VALID = 1'b1;
      end
      if (i == 122) DATA_VALID = 1'b0;
      @(negedge clk);
      i++;
    end
    checks++;
    if (second_start != 81) begin
      failures++;
      $display("FAIL b2b_spacing got=%0d exp=81", second_start);
    end
  endtask

  task automatic test_clamp();
    int i;
    int busy_cycles;
    logic [1:0] e;
    start_frame(8'hFF, 1'b0, 1'b0, 6'd2);
    i = 0;
    busy_cycles = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({busy, TX_OUT} !== e) begin
        failures++;
        $display("FAIL clamp cyc=%0d got=%b exp=%b", i, {busy, TX_OUT}, e);
      end
      if (busy) busy_cycles++;
      @(negedge clk);
      i++;
    end
    checks++;
    if (busy_cycles != 40 || {busy, TX_OUT} !== 2'b01) begin
      failures++;
      $display("FAIL clamp_len got=%0d/%b exp=40/01", busy_cycles, {busy, TX_OUT});
    end
  endtask

  task automatic test_reset_mid();
    int i;
    logic [1:0] e;
    start_frame(8'h00, 1'b0, 1'b0, 6'd8);
    // data bit 3 occupies cycles 32..39 of the frame
    for (i = 0; i < 36; i++) begin
      e = exp_q.pop_front();
      checks++;
      if ({busy, TX_OUT} !== e) begin
        failures++;
        $display("FAIL rstmid_pre cyc=%0d got=%b exp=%b", i, {busy, TX_OUT}, e);
      end
      @(negedge clk);
    end
    exp_q.delete();
    rst        = 1'b1;
    DATA_VALID = 1'b1;
    P_DATA     = 8'hFF;
    @(negedge clk);
    rst        = 1'b0;
    DATA_VALID = 1'b0;
    checks++;
    if ({busy, TX_OUT} !== 2'b01) begin
      failures++;
      $display("FAIL rstmid_abort got=%b exp=01", {busy, TX_OUT});
    end
    @(negedge clk);
    checks++;
    if ({busy, TX_OUT} !== 2'b01) begin
      failures++;
      $display("FAIL rstmid_no_accept got=%b exp=01", {busy, TX_OUT});
    end
    start_frame(8'h3C, 1'b1, 1'b0, 6'd6);
    i = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({busy, TX_OUT} !== e) begin
        failures++;
        $display("FAIL rstmid_post cyc=%0d got=%b exp=%b", i, {busy, TX_OUT}, e);
      end
      @(negedge clk);
      i++;
    end
    checks++;
    if ({busy, TX_OUT} !== 2'b01) begin
      failures++;
      $display("FAIL rstmid_end got=%b exp=01", {busy, TX_OUT});
    end
  endtask

  task automatic test_random();
    int i;
    logic [7:0] d;
    logic [1:0] e;
    for (int f = 0; f < 3; f++) begin
      d = 8'($urandom_range(0, 255));
      start_frame(d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  6'($urandom_range(0, 12)));
      i = 0;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({busy, TX_OUT} !== e) begin
          failures++;
          $display("FAIL rand f=%0d d=%h cyc=%0d got=%b exp=%b", f, d, i, {busy, TX_OUT}, e);
        end
        @(negedge clk);
        i++;
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    P_DATA     = 8'h00;
    DATA_VALID = 1'b0;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    Prescale   = 6'd8;
    test_reset();
    test_plain();
    test_even_parity();
    test_odd_parity();
    test_back_to_back();
    test_clamp();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
